// File: rtl/mpc_types.sv
// Shared types and constants for the xbar requester path (ROB banks, issuer states).
package mpc_types;

    localparam int MPC_ROB_BANKS = 4;

    // A depth of one still needs a one-bit id field.
    function automatic int rob_id_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALLOC = 2'd1,
        ISSUE = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/rob_crdt_cnt.sv
// Credit pool for an xbar client: returns refill, takes consume, and the pool never exceeds its initial size.
module rob_crdt_cnt #(
    parameter int INIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rtn,
    input  logic       take,
    output logic       avail,
    output logic       ovf,
    output logic [7:0] crdt
);

    localparam logic [7:0] INIT_C = 8'(INIT);

    // A return into a full pool means the far side returned more credits than it was ever given.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crdt <= INIT_C;
            ovf  <= 1'b0;
        end else if (rtn && !take) begin
            if (crdt == INIT_C) begin
                ovf <= 1'b1;
            end else begin
                crdt <= crdt + 8'd1;
            end
        end else if (take && !rtn) begin
            crdt <= crdt - 8'd1;
        end
    end

    assign avail = (crdt != 8'd0);

endmodule

// File: rtl/rob_req_issuer.sv
// Requester-side ROB issuer: allocates a ROB slot per upstream read, then forwards the tagged read command.
module rob_req_issuer
    import mpc_types::*;
#(
    parameter int ROB_DEPTH = 16,
    parameter int ADDR_W    = 32,
    parameter int CRDT_INIT = 8,
    localparam int RW       = rob_id_w(ROB_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              u_req_valid,
    output logic              u_req_ready,
    input  logic [ADDR_W-1:0] u_req_addr,
    input  logic [1:0]        u_req_bank_id,
    output logic              d_kob_rob_req,
    input  logic              d_kob_rob_ack,
    output logic [1:0]        d_kob_rob_bank_id,
    output logic              d_rd_valid,
    input  logic              d_rd_ready,
    output logic [ADDR_W-1:0] d_rd_addr,
    output logic [RW-1:0]     d_rd_rob_id,
    output logic [1:0]        d_rd_bank_id,
    input  logic              d_xbar_crdt_rtn,
    output logic              crdt_ovf
);

    issuer_state_t     state;
    issuer_state_t     next_state;
    logic              alive;
    logic              avail;
    logic              accept;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        bank_q;
    logic [RW-1:0]     rob_id_q;
    logic [RW-1:0]     tail [MPC_ROB_BANKS];
    logic [7:0]        crdt;

    rob_crdt_cnt #(
        .INIT (CRDT_INIT)
    ) u_crdt (
        .clk   (clk),
        .rst   (rst),
        .rtn   (d_xbar_crdt_rtn),
        .take  (accept),
        .avail (avail),
        .ovf   (crdt_ovf),
        .crdt  (crdt)
    );

    // Keeps ready low while reset is held and for the release cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive <= 1'b0;
        end else begin
            alive <= 1'b1;
        end
    end

    assign accept = u_req_valid && u_req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state        = state;
        u_req_ready       = 1'b0;
        d_kob_rob_req     = 1'b0;
        d_kob_rob_bank_id = 2'd0;
        d_rd_valid        = 1'b0;
        d_rd_addr         = '0;
        d_rd_rob_id       = '0;
        d_rd_bank_id      = 2'd0;
        case (state)
            IDLE: begin
                u_req_ready = alive && avail;
                if (u_req_valid && alive && avail) begin
                    next_state = ALLOC;
                end
            end
            ALLOC: begin
                d_kob_rob_req     = 1'b1;
                d_kob_rob_bank_id = bank_q;
                if (d_kob_rob_ack) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                d_rd_valid   = 1'b1;
                d_rd_addr    = addr_q;
                d_rd_rob_id  = rob_id_q;
                d_rd_bank_id = bank_q;
                if (d_rd_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Tails mirror the ROB's per-bank allocation pointer; only an ack in ALLOC advances one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            bank_q   <= 2'd0;
            rob_id_q <= '0;
            for (int i = 0; i < MPC_ROB_BANKS; i++) begin
                tail[i] <= '0;
            end
        end else begin
            if (accept) begin
                addr_q <= u_req_addr;
                bank_q <= u_req_bank_id;
            end
            if (state == ALLOC && d_kob_rob_ack) begin
                rob_id_q     <= tail[bank_q];
                tail[bank_q] <= tail[bank_q] + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rob_req_issuer.sv
// Randomized bench for rob_req_issuer against a per-bank slot counter and credit-pool model.
module tb_rob_req_issuer;

    localparam int ROB_DEPTH = 16;
    localparam int ADDR_W    = 32;
    localparam int CRDT_INIT = 8;
    localparam int RW        = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              u_req_valid;
    logic              u_req_ready;
    logic [ADDR_W-1:0] u_req_addr;
    logic [1:0]        u_req_bank_id;
    logic              d_kob_rob_req;
    logic              d_kob_rob_ack;
    logic [1:0]        d_kob_rob_bank_id;
    logic              d_rd_valid;
    logic              d_rd_ready;
    logic [ADDR_W-1:0] d_rd_addr;
    logic [RW-1:0]     d_rd_rob_id;
    logic [1:0]        d_rd_bank_id;
    logic              d_xbar_crdt_rtn;
    logic              crdt_ovf;

    int vectors    = 0;
    int miscompares = 0;
    int mCrdt;
    int mOvf;
    int mTail [4];

    rob_req_issuer #(
        .ROB_DEPTH (ROB_DEPTH),
        .ADDR_W    (ADDR_W),
        .CRDT_INIT (CRDT_INIT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .u_req_valid       (u_req_valid),
        .u_req_ready       (u_req_ready),
        .u_req_addr        (u_req_addr),
        .u_req_bank_id     (u_req_bank_id),
        .d_kob_rob_req     (d_kob_rob_req),
        .d_kob_rob_ack     (d_kob_rob_ack),
        .d_kob_rob_bank_id (d_kob_rob_bank_id),
        .d_rd_valid        (d_rd_valid),
        .d_rd_ready        (d_rd_ready),
        .d_rd_addr         (d_rd_addr),
        .d_rd_rob_id       (d_rd_rob_id),
        .d_rd_bank_id      (d_rd_bank_id),
        .d_xbar_crdt_rtn   (d_xbar_crdt_rtn),
        .crdt_ovf          (crdt_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mCrdt = CRDT_INIT;
        mOvf  = 0;
        for (int i = 0; i < 4; i++) mTail[i] = 0;
    endtask

    // One clock: credit arithmetic is applied from what was presented before the edge.
    task automatic tick();
        logic acc;
        logic rt;
        acc = u_req_valid && u_req_ready;
        rt  = d_xbar_crdt_rtn;
        @(posedge clk);
        #1;
        if (acc && !rt) mCrdt--;
        else if (rt && !acc) begin
            if (mCrdt == CRDT_INIT) mOvf = 1;
            else mCrdt++;
        end
        checkOutput("crdt", 32'(dut.u_crdt.crdt), 32'(mCrdt));
        checkOutput("crdt_ovf", 32'(crdt_ovf), 32'(mOvf));
    endtask

    task automatic applyStimulus(input logic [1:0] bank, input logic [31:0] addr,
                                 input int ackDly, input int rdyDly,
                                 input bit rtnOnAccept, input bit rtnOnHs,
                                 input bit spurious, input bit abortInIssue);
        int expId;
        int waited;
        waited = 0;
        while (!u_req_ready && waited < 20) begin
            tick();
            waited++;
        end
        checkOutput("ready_before_req", 32'(u_req_ready), 32'd1);
        if (!u_req_ready) return;
        u_req_valid     = 1'b1;
        u_req_addr      = addr;
        u_req_bank_id   = bank;
        d_xbar_crdt_rtn = rtnOnAccept;
        tick();
        u_req_valid     = 1'b0;
        u_req_addr      = $urandom;
        u_req_bank_id   = 2'($urandom);
        d_xbar_crdt_rtn = 1'b0;
        expId = mTail[bank];
        mTail[bank] = (mTail[bank] + 1) % ROB_DEPTH;
        for (int i = 0; i <= ackDly; i++) begin
            checkOutput("kob_req", 32'(d_kob_rob_req), 32'd1);
            checkOutput("kob_bank", 32'(d_kob_rob_bank_id), 32'(bank));
            checkOutput("rd_valid_in_alloc", 32'(d_rd_valid), 32'd0);
            checkOutput("ready_in_alloc", 32'(u_req_ready), 32'd0);
            if (i == ackDly) d_kob_rob_ack = 1'b1;
            tick();
        end
        d_kob_rob_ack = 1'b0;
        checkOutput("kob_req_drop", 32'(d_kob_rob_req), 32'd0);
        if (abortInIssue) return;
        for (int i = 0; i <= rdyDly; i++) begin
            checkOutput("rd_valid", 32'(d_rd_valid), 32'd1);
            checkOutput("rd_addr", d_rd_addr, addr);
            checkOutput("rd_rob_id", 32'(d_rd_rob_id), 32'(expId));
            checkOutput("rd_bank", 32'(d_rd_bank_id), 32'(bank));
            d_kob_rob_ack = spurious && (i != rdyDly) && ($urandom_range(0, 1) == 1);
            if (i == rdyDly) begin
                d_rd_ready      = 1'b1;
                d_xbar_crdt_rtn = rtnOnHs;
            end
            tick();
            d_kob_rob_ack = 1'b0;
        end
        d_rd_ready      = 1'b0;
        d_xbar_crdt_rtn = 1'b0;
        checkOutput("rd_valid_drop", 32'(d_rd_valid), 32'd0);
    endtask

    task automatic pulseReturn(input int n);
        for (int i = 0; i < n; i++) begin
            d_xbar_crdt_rtn = 1'b1;
            tick();
        end
        d_xbar_crdt_rtn = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        u_req_valid = 1'b0;
        u_req_addr = '0;
        u_req_bank_id = 2'd0;
        d_kob_rob_ack = 1'b0;
        d_rd_ready = 1'b0;
        d_xbar_crdt_rtn = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", 32'(u_req_ready), 32'd0);
        checkOutput("reset_kob_req", 32'(d_kob_rob_req), 32'd0);
        checkOutput("reset_rd_valid", 32'(d_rd_valid), 32'd0);
        checkOutput("reset_ovf", 32'(crdt_ovf), 32'd0);
        rst = 1'b0;
        checkOutput("ready_at_release", 32'(u_req_ready), 32'd0);
        tick();
        checkOutput("ready_after_release", 32'(u_req_ready), 32'd1);

        $display("[TB] single request to bank 2");
        applyStimulus(2'd2, 32'h1000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("tail2", 32'(dut.tail[2]), 32'd1);
        checkOutput("crdt_after_first", 32'(dut.u_crdt.crdt), 32'd7);
        pulseReturn(1);

        $display("[TB] 17 back-to-back requests to bank 1");
        for (int k = 0; k < 17; k++)
            applyStimulus(2'd1, $urandom, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("tail0", 32'(dut.tail[0]), 32'd0);
        checkOutput("tail1", 32'(dut.tail[1]), 32'd1);
        checkOutput("tail2_kept", 32'(dut.tail[2]), 32'd1);
        checkOutput("tail3", 32'(dut.tail[3]), 32'd0);

        $display("[TB] drain the credit pool");
        for (int k = 0; k < 8; k++)
            applyStimulus(2'($urandom), $urandom, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ready_empty", 32'(u_req_ready), 32'd0);
        d_xbar_crdt_rtn = 1'b1;
        checkOutput("ready_empty_rtn", 32'(u_req_ready), 32'd0);
        tick();
        d_xbar_crdt_rtn = 1'b0;
        checkOutput("ready_after_rtn", 32'(u_req_ready), 32'd1);
        pulseReturn(7);

        $display("[TB] stalled ack and ready");
        applyStimulus(2'd3, 32'hdead_beef, 5, 3, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] coincident return and overflow");
        applyStimulus(2'd0, 32'h0000_0040, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("crdt_coincident", 32'(dut.u_crdt.crdt), 32'd8);
        pulseReturn(1);
        checkOutput("ovf_set", 32'(crdt_ovf), 32'd1);
        repeat (3) tick();

        $display("[TB] randomized traffic");
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                d_kob_rob_ack   = 1'($urandom);
                d_xbar_crdt_rtn = 1'($urandom);
                tick();
                d_kob_rob_ack   = 1'b0;
                d_xbar_crdt_rtn = 1'b0;
            end
            applyStimulus(2'($urandom), $urandom, $urandom_range(0, 4), $urandom_range(0, 4),
                          1'($urandom), 1'($urandom), 1'b1, 1'b0);
            if (mCrdt < 2) pulseReturn(3);
        end

        $display("[TB] reset while issuing");
        applyStimulus(2'd1, 32'h2222_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("rd_valid_before_rst", 32'(d_rd_valid), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rd_valid_async_drop", 32'(d_rd_valid), 32'd0);
        checkOutput("ready_in_rst", 32'(u_req_ready), 32'd0);
        checkOutput("ovf_cleared", 32'(crdt_ovf), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelReset();
        tick();
        checkOutput("ready_post_rst", 32'(u_req_ready), 32'd1);
        applyStimulus(2'd1, 32'h3333_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("crdt_post_rst", 32'(dut.u_crdt.crdt), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
